mux2_rr_arbiter: RTL and testbench

Two-input round-robin stream arbiter that sits directly upstream of the 2:1 `Mux`. It accepts words from sources A and B over valid/ready handshakes and grants one per cycle, alternating on contention. It registers the winning word and drives a `sel` line whose encoding matches the mux: 0 = a, 1 = b. The downstream mux and consumer see a registered `out_data`/`sel` pair behind a valid/ready handshake.

---
 rtl/mux2_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Two-input round-robin stream arbiter that feeds the 2:1 mux. Words from
// sources A and B arrive over valid/ready handshakes. One word per cycle is
// granted into a single registered output slot, together with a sel bit
// (0 = A, 1 = B). When both sources are valid, the grant alternates.
//
// Ports
//   i_clk, i_rst_n           clock; synchronous active-low reset
//   i_a_valid/i_a_data       source A word,   o_a_ready accepts it
//   i_b_valid/i_b_data       source B word,   o_b_ready accepts it
//   o_out_valid/o_out_data   registered output slot
//   o_sel                    source of the slot word, drives mux sel
//   i_out_ready              consumer takes the slot
//   o_cnt_a/o_cnt_b          per-source accepted-word counters (wrapping)
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | output slot empty, o_out_valid = 0
// ST_FULL  | output slot holds a word, o_out_valid = 1

module mux2_rr_arbiter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_sel,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic w_can_load;
    logic w_gnt_a;
    logic w_gnt_b;
    logic w_acc_a;
    logic w_acc_b;
    logic w_acc;

    // The slot can take a new word when it is empty or is draining this cycle.
    assign w_can_load = (r_state == ST_EMPTY) | i_out_ready;

    // On a tie, grant the source that was not served most recently.
    assign w_gnt_a = i_a_valid & (~i_b_valid | r_last);
    assign w_gnt_b = i_b_valid & (~i_a_valid | ~r_last);

    // Gating with i_rst_n keeps both readies low while reset is held.
    // A grant already implies valid, so these are the accept strobes.
    assign w_acc_a = i_rst_n & w_can_load & w_gnt_a;
    assign w_acc_b = i_rst_n & w_can_load & w_gnt_b;
    assign w_acc   = w_acc_a | w_acc_b;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && i_out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        o_out_valid = (r_state == ST_FULL);
        o_a_ready   = w_acc_a;
        o_b_ready   = w_acc_b;
    end

    // Slot contents, priority pointer and counters.
    // r_last resets to B, so A wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_acc) begin
                r_data <= w_acc_b ? i_b_data : i_a_data;
                r_sel  <= w_acc_b;
                r_last <= w_acc_b;
            end
            if (w_acc_a) begin
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            end
            if (w_acc_b) begin
                r_cnt_b <= r_cnt_b + CNT_W'(1);
            end
        end
    end

    assign o_out_data = r_data;
    assign o_sel      = r_sel;
    assign o_cnt_a    = r_cnt_a;
    assign o_cnt_b    = r_cnt_b;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [0:0] a_data, b_data;

    logic       a_ready, b_ready, out_valid, sel;
    logic [0:0] out_data;
    logic [7:0] cnt_a, cnt_b;

    logic       a_ready2, b_ready2, out_valid2, sel2;
    logic [0:0] out_data2;
    logic [1:0] cnt_a2, cnt_b2;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard entries: {sel, data}
    logic [1:0] exp_q[$];

    mux2_rr_arbiter #(.WIDTH(1), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready),
        .o_out_valid(out_valid), .o_out_data(out_data), .o_sel(sel),
        .i_out_ready(out_ready),
        .o_cnt_a(cnt_a), .o_cnt_b(cnt_b)
    );

    // Narrow-counter instance for the wrap test, driven by the same stimulus.
    mux2_rr_arbiter #(.WIDTH(1), .CNT_W(2)) u_dut_w2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready2),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready2),
        .o_out_valid(out_valid2), .o_out_data(out_data2), .o_sel(sel2),
        .i_out_ready(out_ready),
        .o_cnt_a(cnt_a2), .o_cnt_b(cnt_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: each word the consumer takes is compared to the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {30'd0, sel, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("sb_sel", {31'd0, sel}, {31'd0, e[1]});
                check("sb_data", {31'd0, out_data}, {31'd0, e[0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat_a;
        int         ctn_sel[6] = '{0, 1, 0, 1, 0, 1};
        int         wrap_exp[5] = '{1, 2, 3, 0, 1};

        // Reset held 3 cycles with both sources valid
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 1'b1;
        b_data    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_sel", {31'd0, sel}, 32'd0);
            check("rst_cnt_a", {24'd0, cnt_a}, 32'd0);
            check("rst_cnt_b", {24'd0, cnt_b}, 32'd0);
            check("rst_a_ready", {31'd0, a_ready}, 32'd0);
            check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("tie_a_ready", {31'd0, a_ready}, 32'd1);
        check("tie_b_ready", {31'd0, b_ready}, 32'd0);
        exp_q.push_back({1'b0, 1'b1});
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("tie_out_valid", {31'd0, out_valid}, 32'd1);
        check("tie_cnt_a", {24'd0, cnt_a}, 32'd1);
        tick();
        #1;
        check("tie_drained", {31'd0, out_valid}, 32'd0);

        // Single-source streaming from A: 1,0,1,1
        do_reset();
        pat_a = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = pat_a[i];
            exp_q.push_back({1'b0, pat_a[i]});
            tick();
        end
        a_valid = 1'b0;
        #1;
        check("stream_cnt_a", {24'd0, cnt_a}, 32'd4);
        check("stream_cnt_b", {24'd0, cnt_b}, 32'd0);
        tick();
        tick();
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Contention: grants alternate A,B,A,B,A,B
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 1'b0;
        b_data  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({ctn_sel[i][0], ctn_sel[i][0]});
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("ctn_cnt_a", {24'd0, cnt_a}, 32'd3);
        check("ctn_cnt_b", {24'd0, cnt_b}, 32'd3);
        tick();
        tick();

        // Backpressure: A's word held while B waits, then replaced without bubble
        do_reset();
        a_valid   = 1'b1;
        a_data    = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b1});
        tick();
        a_valid   = 1'b0;
        b_valid   = 1'b1;
        b_data    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_b_ready", {31'd0, b_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {31'd0, out_data}, 32'd1);
            check("bp_sel", {31'd0, sel}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_b_ready", {31'd0, b_ready}, 32'd1);
        exp_q.push_back({1'b1, 1'b0});
        tick();
        b_valid = 1'b0;
        #1;
        check("bp_no_bubble", {31'd0, out_valid}, 32'd1);
        check("bp_new_sel", {31'd0, sel}, 32'd1);
        check("bp_new_data", {31'd0, out_data}, 32'd0);
        tick();
        #1;
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Drain to empty after a single word from B
        do_reset();
        b_valid = 1'b1;
        b_data  = 1'b1;
        exp_q.push_back({1'b1, 1'b1});
        tick();
        b_valid = 1'b0;
        #1;
        check("drain_full", {31'd0, out_valid}, 32'd1);
        check("drain_cnt_b", {24'd0, cnt_b}, 32'd1);
        tick();
        #1;
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_sel_hold", {31'd0, sel}, 32'd1);
        check("drain_data_hold", {31'd0, out_data}, 32'd1);

        // Counter wrap on the 2-bit instance
        do_reset();
        a_valid = 1'b1;
        a_data  = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 1'b1});
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("wrap_cnt_a2", {30'd0, cnt_a2}, wrap_exp[i]);
        end
        a_valid = 1'b0;
        check("wrap_cnt_a8", {24'd0, cnt_a}, 32'd5);
        tick();
        tick();

        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
